// File: rtl/ssp_pkg.sv
// ---------------------------------------------------------------------------
// ssp_pkg
// Shared types for the APB requester slice.
//   apb_state_e : requester bus phase (IDLE, SETUP, ACCESS)
//   apb_cmd_t   : queued command {write, addr, wdata}. Fields are sized to
//                 the widest supported bus; users zero-extend into it and
//                 take back only the bits their instance needs.
//   rsp_slot_free : decides whether a new transfer may start without
//                   overrunning the response buffer.
// ---------------------------------------------------------------------------
package ssp_pkg;

  localparam int CMD_ADDR_W_MAX = 32;
  localparam int CMD_DATA_W_MAX = 32;
  localparam int RSP_DEPTH      = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  typedef struct packed {
    logic                      write;
    logic [CMD_ADDR_W_MAX-1:0] addr;
    logic [CMD_DATA_W_MAX-1:0] wdata;
  } apb_cmd_t;

  // Occupancy the response buffer will have after this edge, plus the one
  // transfer that would be started, must still fit. A pop only happens when
  // occupancy is non-zero, so the sum never goes negative.
  function automatic logic rsp_slot_free(input logic [1:0] occupancy,
                                         input logic       push,
                                         input logic       pop);
    int n;
    n = int'(occupancy) + int'(push) - int'(pop) + 1;
    return (n <= RSP_DEPTH);
  endfunction

endpackage

// File: rtl/apb_cmd_fifo.sv
// ---------------------------------------------------------------------------
// apb_cmd_fifo
// Synchronous command FIFO, DEPTH entries of WIDTH bits (DEPTH a power of
// two, >= 2). Pointers wrap naturally modulo DEPTH. A push while full or a
// pop while empty is ignored, so a full FIFO never takes a push even when a
// pop happens on the same edge.
// Ports:
//   clk, rst      clock, asynchronous active-high reset (empties the FIFO)
//   push, wdata   write strobe and data
//   pop, rdata    read strobe and head-of-queue data (valid when !empty)
//   count         current occupancy, 0..DEPTH
//   empty         no entries held
// ---------------------------------------------------------------------------
module apb_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage needs no reset: it is only read through rd_ptr when count > 0.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/apb_requester.sv
// ---------------------------------------------------------------------------
// apb_requester
// Queues read/write commands and issues them as APB transfers without
// PREADY (every transfer is one SETUP plus one ACCESS cycle). Completed
// transfers land in a 2-entry response buffer; a transfer only starts when
// its response is guaranteed a slot, so nothing is ever dropped.
//
// State | meaning
// ------+-------------------------------------------------------------
// IDLE  | bus idle, PSEL=0; waits for a command and a free response slot
// SETUP | PSEL=1, PENABLE=0; head command was popped into PADDR/PWRITE/PWDATA
// ACCESS| PSEL=1, PENABLE=1; PRDATA sampled and response pushed at its end
//
// Parameters: FIFO_DEPTH (command entries, power of two >= 2),
//             ADDR_W (word address, <= 32), DATA_W (<= 32)
// Ports:
//   PCLK, PRESET                 clock, asynchronous active-high reset
//   cmd_valid/cmd_ready          command handshake
//   cmd_write, cmd_addr, cmd_wdata   command payload
//   rsp_valid/rsp_ready          response handshake
//   rsp_write, rsp_rdata         response payload (rdata is 0 for writes)
//   PSEL, PENABLE, PWRITE, PADDR, PWDATA   registered APB request
//   PRDATA                       completer read data
// ---------------------------------------------------------------------------
module apb_requester
  import ssp_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA
);

  localparam int CMD_W = 1 + ADDR_W + DATA_W;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  apb_state_e        state;
  apb_state_e        state_nxt;
  logic              start;
  logic              run;

  logic [CMD_W-1:0]  fifo_wdata;
  logic [CMD_W-1:0]  fifo_rdata;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;
  logic              cmd_push;
  apb_cmd_t          head;
  logic              unused_head;

  logic [DATA_W:0]   rsp_mem [RSP_DEPTH];
  logic              rsp_wr_ptr;
  logic              rsp_rd_ptr;
  logic [1:0]        rsp_count;
  logic              rsp_push;
  logic              rsp_pop;
  logic              issue_ok;

  // ---------------- command FIFO ----------------
  // run stays low through reset and rises on the first edge after it, which
  // keeps cmd_ready low while PRESET is asserted.
  assign cmd_ready  = run && (fifo_count < CNT_W'(FIFO_DEPTH));
  assign cmd_push   = cmd_valid && cmd_ready;
  assign fifo_wdata = {cmd_write, cmd_addr, cmd_wdata};

  apb_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_cmd_fifo (
    .clk   (PCLK),
    .rst   (PRESET),
    .push  (cmd_push),
    .wdata (fifo_wdata),
    .pop   (start),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  always_comb begin
    head.write = fifo_rdata[CMD_W-1];
    head.addr  = CMD_ADDR_W_MAX'(fifo_rdata[DATA_W +: ADDR_W]);
    head.wdata = CMD_DATA_W_MAX'(fifo_rdata[DATA_W-1:0]);
  end

  // Upper struct bits are zero-extension only.
  assign unused_head = ^{head.addr, head.wdata};

  // ---------------- transfer sequencing ----------------
  assign rsp_push = (state == ACCESS);
  assign rsp_pop  = rsp_valid && rsp_ready;
  assign issue_ok = rsp_slot_free(rsp_count, rsp_push, rsp_pop);

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    unique case (state)
      IDLE: begin
        if (!fifo_empty && issue_ok) begin
          state_nxt = SETUP;
          start     = 1'b1;
        end
      end
      SETUP: begin
        state_nxt = ACCESS;
      end
      ACCESS: begin
        if (!fifo_empty && issue_ok) begin
          state_nxt = SETUP;
          start     = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state   <= IDLE;
      run     <= 1'b0;
      PSEL    <= 1'b0;
      PENABLE <= 1'b0;
      PWRITE  <= 1'b0;
      PADDR   <= '0;
      PWDATA  <= '0;
    end else begin
      state   <= state_nxt;
      run     <= 1'b1;
      PSEL    <= (state_nxt != IDLE);
      PENABLE <= (state_nxt == ACCESS);
      // Request fields change only when a new transfer begins, so they hold
      // through ACCESS and keep their last values while idle.
      if (start) begin
        PWRITE <= head.write;
        PADDR  <= head.addr[ADDR_W-1:0];
        PWDATA <= head.write ? head.wdata[DATA_W-1:0] : '0;
      end
    end
  end

  // ---------------- response buffer ----------------
  // Never pushed while full: issue_ok reserved the slot before SETUP.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      rsp_wr_ptr <= 1'b0;
      rsp_rd_ptr <= 1'b0;
      rsp_count  <= '0;
    end else begin
      if (rsp_push) rsp_wr_ptr <= ~rsp_wr_ptr;
      if (rsp_pop)  rsp_rd_ptr <= ~rsp_rd_ptr;
      rsp_count <= rsp_count + 2'(rsp_push) - 2'(rsp_pop);
    end
  end

  always_ff @(posedge PCLK) begin
    if (rsp_push) rsp_mem[rsp_wr_ptr] <= {PWRITE, PWRITE ? {DATA_W{1'b0}} : PRDATA};
  end

  assign rsp_valid = (rsp_count != '0);
  assign rsp_write = rsp_valid && rsp_mem[rsp_rd_ptr][DATA_W];
  assign rsp_rdata = rsp_valid ? rsp_mem[rsp_rd_ptr][DATA_W-1:0] : '0;

endmodule

// File: tb/tb_apb_requester.sv
// ---------------------------------------------------------------------------
// tb_apb_requester
// Transaction-level reference model (command/response queues plus the
// current transfer's phase) compared against the DUT on every falling edge,
// directed scenarios with literal expectations, then randomized traffic
// with occasional reset pulses.
// ---------------------------------------------------------------------------
module tb_apb_requester;

  localparam int DEPTH = 4;
  localparam int AW    = 10;
  localparam int DW    = 16;

  logic          PCLK = 1'b0;
  logic          PRESET;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_write;
  logic [DW-1:0] rsp_rdata;
  logic          PSEL;
  logic          PENABLE;
  logic          PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic [DW-1:0] PRDATA;

  always #5 PCLK = ~PCLK;

  apb_requester #(
    .FIFO_DEPTH (DEPTH),
    .ADDR_W     (AW),
    .DATA_W     (DW)
  ) dut (
    .PCLK      (PCLK),
    .PRESET    (PRESET),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_write (rsp_write),
    .rsp_rdata (rsp_rdata),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PRDATA    (PRDATA)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } cmd_s;

  cmd_s          cmd_q[$];
  logic [DW:0]   rsp_q[$];
  bit            busy      = 0;   // a transfer is on the bus
  int            age       = 0;   // 0: its first cycle, 1: its second cycle
  bit            m_started = 0;
  logic          m_w       = 0;
  logic [AW-1:0] m_a       = '0;
  logic [DW-1:0] m_d       = '0;

  bit   m_acc, m_pop, m_push, m_go;
  int   m_after;
  cmd_s m_c;

  always @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      cmd_q.delete();
      rsp_q.delete();
      busy = 0; age = 0; m_started = 0;
      m_w = 0; m_a = '0; m_d = '0;
    end else begin
      m_acc   = cmd_valid && m_started && (cmd_q.size() < DEPTH);
      m_pop   = (rsp_q.size() > 0) && rsp_ready;
      m_push  = busy && (age == 1);
      m_after = rsp_q.size() + int'(m_push) - int'(m_pop);
      m_go    = (!busy || age == 1) && (cmd_q.size() > 0) && (m_after + 1 <= 2);
      if (m_pop)  void'(rsp_q.pop_front());
      if (m_push) rsp_q.push_back({m_w, m_w ? {DW{1'b0}} : PRDATA});
      if (m_go) begin
        m_c  = cmd_q.pop_front();
        m_w  = m_c.w;
        m_a  = m_c.a;
        m_d  = m_c.w ? m_c.d : '0;
        busy = 1;
        age  = 0;
      end else if (busy && age == 0) begin
        age = 1;
      end else begin
        busy = 0;
      end
      if (m_acc) begin
        m_c.w = cmd_write; m_c.a = cmd_addr; m_c.d = cmd_wdata;
        cmd_q.push_back(m_c);
      end
      m_started = 1;
    end
  end

  // ---------------- per-cycle compare and bus monitor ----------------
  int n_access = 0;
  int psel_run = 0;
  int max_run  = 0;

  always @(negedge PCLK) begin
    chk("cmd_ready", cmd_ready, m_started && (cmd_q.size() < DEPTH));
    chk("psel", PSEL, busy);
    chk("penable", PENABLE, busy && (age == 1));
    chk("pwrite", PWRITE, m_w);
    chk("paddr", PADDR, m_a);
    chk("pwdata", PWDATA, m_d);
    chk("rsp_valid", rsp_valid, rsp_q.size() > 0);
    if (rsp_q.size() > 0) begin
      chk("rsp_write", rsp_write, rsp_q[0][DW]);
      chk("rsp_rdata", rsp_rdata, rsp_q[0][DW-1:0]);
    end
    if (PENABLE) n_access++;
    if (PSEL) psel_run++; else psel_run = 0;
    if (psel_run > max_run) max_run = psel_run;
  end

  bit prdata_rand = 0;
  always @(posedge PCLK) begin
    #2;
    if (prdata_rand) PRDATA = DW'($urandom);
  end

  // ---------------- stimulus helpers ----------------
  // Called and returning at 2 time units after a rising edge.
  task automatic send(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int k;
    k = 0;
    while (!cmd_ready && k < 60) begin
      @(posedge PCLK); #2;
      k++;
    end
    chk("send_ready", cmd_ready, 1);
    cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    @(posedge PCLK); #2;
    cmd_valid = 0;
  endtask

  initial begin
    #400000;
    failures++;
    $display("FAIL global_timeout checks=%0d", checks);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  int acc;
  int base;
  bit got;
  bit was;

  initial begin
    PRESET = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1; PRDATA = '0;
    repeat (3) @(posedge PCLK);
    #2;
    chk("rst_psel", PSEL, 0);
    chk("rst_penable", PENABLE, 0);
    chk("rst_pwrite", PWRITE, 0);
    chk("rst_paddr", PADDR, 0);
    chk("rst_pwdata", PWDATA, 0);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_write", rsp_write, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    PRESET = 0;
    @(posedge PCLK); #2;
    chk("ready_after_reset", cmd_ready, 1);

    // Single write: accept at edge N, SETUP after N+1, ACCESS after N+2,
    // response visible after N+3.
    send(1'b1, 10'h00C, 16'h00A5);
    @(negedge PCLK);
    chk("w_n_psel", PSEL, 0);
    @(negedge PCLK);
    chk("w_setup_psel", PSEL, 1);
    chk("w_setup_penable", PENABLE, 0);
    chk("w_setup_paddr", PADDR, 32'h00C);
    chk("w_setup_pwrite", PWRITE, 1);
    chk("w_setup_pwdata", PWDATA, 32'h00A5);
    @(negedge PCLK);
    chk("w_access_penable", PENABLE, 1);
    chk("w_access_paddr", PADDR, 32'h00C);
    chk("w_access_pwdata", PWDATA, 32'h00A5);
    chk("w_access_rsp_valid", rsp_valid, 0);
    @(negedge PCLK);
    chk("w_rsp_valid", rsp_valid, 1);
    chk("w_rsp_write", rsp_write, 1);
    chk("w_rsp_rdata", rsp_rdata, 0);
    chk("w_done_psel", PSEL, 0);
    repeat (3) @(posedge PCLK);
    #2;

    // Single read with fixed completer data.
    PRDATA = 16'h1234;
    send(1'b0, 10'h006, 16'hFFFF);
    @(negedge PCLK);
    @(negedge PCLK);
    chk("r_setup_paddr", PADDR, 32'h006);
    chk("r_setup_pwrite", PWRITE, 0);
    chk("r_setup_pwdata", PWDATA, 0);
    @(negedge PCLK);
    chk("r_access_penable", PENABLE, 1);
    @(negedge PCLK);
    chk("r_rsp_valid", rsp_valid, 1);
    chk("r_rsp_write", rsp_write, 0);
    chk("r_rsp_rdata", rsp_rdata, 32'h1234);
    repeat (3) @(posedge PCLK);
    #2;

    // Response back-pressure: only two transfers may complete.
    prdata_rand = 1;
    rsp_ready   = 0;
    base        = n_access;
    for (int i = 0; i < 4; i++) send(1'b0, AW'(10'h020 + i), 16'h0);
    repeat (12) @(posedge PCLK);
    #2;
    chk("bp_transfers", n_access - base, 2);
    chk("bp_psel_idle", PSEL, 0);
    chk("bp_rsp_valid", rsp_valid, 1);

    // Fill the command FIFO until cmd_ready drops, then hold one more.
    acc = 0;
    cmd_valid = 1; cmd_write = 0;
    for (int k = 0; k < 8; k++) begin
      if (!cmd_ready) break;
      cmd_addr = AW'(10'h040 + k);
      @(posedge PCLK); #2;
      acc++;
    end
    chk("fill_accepted", acc, 2);
    chk("fill_ready_low", cmd_ready, 0);
    cmd_addr  = 10'h050;
    rsp_ready = 1;
    base      = n_access;
    max_run   = 0;
    got       = 0;
    for (int k = 0; k < 30; k++) begin
      was = cmd_ready;
      @(posedge PCLK); #2;
      if (was) begin
        got = 1;
        cmd_valid = 0;
        break;
      end
    end
    chk("held_cmd_accepted", got, 1);
    repeat (20) @(posedge PCLK);
    #2;
    chk("resume_transfers", n_access - base, 5);
    chk("no_idle_gap_run", max_run, 10);

    // Reset in the middle of ACCESS with a second command queued.
    prdata_rand = 0;
    PRDATA      = 16'hBEEF;
    send(1'b0, 10'h030, 16'h0);
    send(1'b1, 10'h031, 16'h5555);
    got = 0;
    for (int k = 0; k < 20; k++) begin
      if (PENABLE) begin
        got = 1;
        break;
      end
      @(posedge PCLK); #2;
    end
    chk("reached_access", got, 1);
    #4;
    PRESET = 1;
    #1;
    chk("arst_psel", PSEL, 0);
    chk("arst_penable", PENABLE, 0);
    chk("arst_rsp_valid", rsp_valid, 0);
    chk("arst_cmd_ready", cmd_ready, 0);
    @(posedge PCLK); #2;
    PRESET = 0;
    base = n_access;
    repeat (10) @(posedge PCLK);
    #2;
    chk("arst_no_transfer", n_access - base, 0);
    chk("arst_no_response", rsp_valid, 0);
    send(1'b0, 10'h018, 16'h0);
    got = 0;
    for (int k = 0; k < 20; k++) begin
      if (rsp_valid) begin
        got = 1;
        break;
      end
      @(posedge PCLK); #2;
    end
    chk("post_rst_rsp_seen", got, 1);
    chk("post_rst_rsp_write", rsp_write, 0);
    chk("post_rst_rsp_rdata", rsp_rdata, 32'hBEEF);
    repeat (3) @(posedge PCLK);
    #2;

    // Randomized traffic with phases of heavy back-pressure and rare resets.
    prdata_rand = 1;
    for (int i = 0; i < 3000; i++) begin
      cmd_valid = ($urandom_range(0, 2) != 0);
      cmd_write = 1'($urandom_range(0, 1));
      cmd_addr  = AW'($urandom);
      cmd_wdata = DW'($urandom);
      if ((i % 600) < 200) rsp_ready = ($urandom_range(0, 5) == 0);
      else                 rsp_ready = ($urandom_range(0, 3) != 0);
      PRESET = ($urandom_range(0, 499) == 0);
      @(posedge PCLK); #2;
    end
    PRESET    = 0;
    cmd_valid = 0;
    rsp_ready = 1;
    repeat (30) @(posedge PCLK);
    #2;
    chk("drain_rsp_empty", rsp_valid, 0);
    chk("drain_bus_idle", PSEL, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
